// File: rtl/sync_counter_pkg.sv
// Shared constants for the 3-bit T-flop up/down counter.
//   COUNT_W   : counter width in bits
//   MODE_UP   : m encoding for counting up
//   MODE_DOWN : m encoding for counting down
package sync_counter_pkg;

    localparam int   COUNT_W   = 3;
    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/sync_counter_t_ff.sv
// Toggle flip-flop with asynchronous active-low clear.
//   clk   in  : rising-edge clock
//   reset in  : async clear, active low (0 forces q=0)
//   t     in  : toggle enable; q inverts on the edge when t=1
//   q     out : flop state
module t_ff (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q <= 1'b0;
        else        q <= q ^ t;
    end

endmodule

// File: rtl/sync_counter.sv
// 3-bit synchronous up/down counter built from three T flip-flops on one clock.
//   clk   in  : rising-edge clock
//   reset in  : async clear, active low
//   m     in  : direction, MODE_UP (0) counts up, MODE_DOWN (1) counts down
//   ta    in  : count enable (T input of the LSB stage); 0 holds
//   qa    out : count bit 0 (LSB)
//   qb    out : count bit 1
//   qc    out : count bit 2 (MSB)
module sync_counter
    import sync_counter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic m,
    input  logic ta,
    output logic qa,
    output logic qb,
    output logic qc
);

    localparam int NBITS = COUNT_W;

    logic [NBITS-1:0] q;
    logic [NBITS-1:0] t;
    logic [NBITS-1:0] q_sel;

    // Counting down is counting up on the complemented state, so the
    // ripple-enable chain looks at ~q in down mode: a stage toggles when
    // all lower stages are 1 (up) or all lower stages are 0 (down).
    always_comb begin
        q_sel = (m == MODE_DOWN) ? ~q : q;
        t[0]  = ta;
        t[1]  = ta & q_sel[0];
        t[2]  = ta & q_sel[0] & q_sel[1];
    end

    for (genvar i = 0; i < NBITS; i++) begin : g_stage
        t_ff u_tff (
            .clk   (clk),
            .reset (reset),
            .t     (t[i]),
            .q     (q[i])
        );
    end

    assign qa = q[0];
    assign qb = q[1];
    assign qc = q[2];

endmodule

// File: tb/tb_sync_counter.sv
// Self-checking bench for sync_counter: scoreboard of expected counts pushed
// as stimulus is driven and popped after each clock edge.
module tb_sync_counter;
    import sync_counter_pkg::*;

    logic clk;
    logic reset;
    logic m;
    logic ta;
    logic qa, qb, qc;

    int tests = 0;
    int fails = 0;

    logic [2:0] model_q;
    logic [2:0] exp_q [$];
    logic [2:0] got;
    logic [2:0] expv;

    sync_counter dut (
        .clk   (clk),
        .reset (reset),
        .m     (m),
        .ta    (ta),
        .qa    (qa),
        .qb    (qb),
        .qc    (qc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // Drive one cycle of stimulus (1ns after the previous edge), push the
    // reference-model result, advance to 1ns past the next rising edge.
    task automatic cycle(input logic mm, input logic tt);
        m  = mm;
        ta = tt;
        if (!reset)       model_q = 3'd0;
        else if (tt)      model_q = (mm == MODE_DOWN) ? model_q - 3'd1 : model_q + 3'd1;
        exp_q.push_back(model_q);
        @(posedge clk);
        #1;
    endtask

    // Async reset pulse well inside the cycle, released before the next edge.
    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        tests++;
        if ({qc, qb, qa} !== 3'd0) begin
            fails++;
            $display("FAIL async_reset_pulse: got %0d expected 0", {qc, qb, qa});
        end
        reset = 1'b1;
        model_q = 3'd0;
    endtask

    task automatic test_reset();
        // Reset held low from time 0.
        #1;
        tests++;
        if ({qc, qb, qa} !== 3'd0) begin
            fails++;
            $display("FAIL reset_initial: got %0d expected 0", {qc, qb, qa});
        end
        model_q = 3'd0;
        for (int i = 0; i < 3; i++) begin
            cycle(MODE_UP, 1'b1);
            expv = exp_q.pop_front();
            tests++;
            if ({qc, qb, qa} !== expv) begin
                fails++;
                $display("FAIL reset_hold edge%0d: got %0d expected %0d", i, {qc, qb, qa}, expv);
            end
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) cycle(MODE_UP, 1'b1);
        for (int i = 0; i < 5; i++) begin
            expv = exp_q.pop_front();
            if (i == 4) begin
                tests++;
                if ({qc, qb, qa} !== expv || expv !== 3'd5) begin
                    fails++;
                    $display("FAIL reset_reach5: got %0d expected %0d", {qc, qb, qa}, expv);
                end
            end
        end
        pulse_reset();
    endtask

    task automatic test_up();
        pulse_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(MODE_UP, 1'b1);
            expv = exp_q.pop_front();
            tests++;
            if ({qc, qb, qa} !== expv) begin
                fails++;
                $display("FAIL up_count step%0d: got %0d expected %0d", i, {qc, qb, qa}, expv);
            end
        end
    endtask

    task automatic test_down();
        pulse_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(MODE_DOWN, 1'b1);
            expv = exp_q.pop_front();
            tests++;
            if ({qc, qb, qa} !== expv) begin
                fails++;
                $display("FAIL down_count step%0d: got %0d expected %0d", i, {qc, qb, qa}, expv);
            end
        end
    endtask

    task automatic test_hold();
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(MODE_UP, 1'b1);
            void'(exp_q.pop_front());
        end
        for (int i = 0; i < 4; i++) begin
            cycle((i < 2) ? MODE_UP : MODE_DOWN, 1'b0);
            expv = exp_q.pop_front();
            tests++;
            if ({qc, qb, qa} !== expv || expv !== 3'd3) begin
                fails++;
                $display("FAIL hold edge%0d: got %0d expected %0d", i, {qc, qb, qa}, expv);
            end
        end
        cycle(MODE_UP, 1'b1);
        expv = exp_q.pop_front();
        tests++;
        if ({qc, qb, qa} !== expv || expv !== 3'd4) begin
            fails++;
            $display("FAIL hold_resume: got %0d expected %0d", {qc, qb, qa}, expv);
        end
    endtask

    task automatic test_switch();
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(MODE_UP, 1'b1);
            void'(exp_q.pop_front());
        end
        tests++;
        if ({qc, qb, qa} !== 3'd4) begin
            fails++;
            $display("FAIL switch_pre: got %0d expected 4", {qc, qb, qa});
        end
        // Direction change mid-cycle must not disturb the held value.
        m = MODE_DOWN;
        #2;
        tests++;
        if ({qc, qb, qa} !== 3'd4) begin
            fails++;
            $display("FAIL switch_midcycle: got %0d expected 4", {qc, qb, qa});
        end
        for (int i = 0; i < 2; i++) begin
            cycle(MODE_DOWN, 1'b1);
            expv = exp_q.pop_front();
            tests++;
            if ({qc, qb, qa} !== expv) begin
                fails++;
                $display("FAIL switch_down step%0d: got %0d expected %0d", i, {qc, qb, qa}, expv);
            end
        end
    endtask

    task automatic test_random();
        logic rm, rt;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 24) == 0) pulse_reset();
            rm = 1'($urandom_range(0, 1));
            rt = 1'($urandom_range(0, 3) != 0);
            cycle(rm, rt);
            expv = exp_q.pop_front();
            tests++;
            if ({qc, qb, qa} !== expv) begin
                fails++;
                $display("FAIL random edge%0d m=%0d ta=%0d: got %0d expected %0d",
                         i, rm, rt, {qc, qb, qa}, expv);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        m     = MODE_UP;
        ta    = 1'b0;
        model_q = 3'd0;
        test_reset();
        test_up();
        test_down();
        test_hold();
        test_switch();
        test_random();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
